// File: rtl/hilo_ctrl.sv
// hilo_ctrl: multiply/divide sequencer that owns the HI/LO write port.
// Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time, stalls the
// pipeline while a multi-cycle operation runs, then commits HI and LO
// together in a single write cycle. A flush abandons the operation without
// writing HI/LO.
// Build option: define HILO_CTRL_DIV_EN to include the 32-cycle restoring
// divider; without it DIV/DIVU complete in one cycle and write HI=0, LO=0.
module hilo_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic        busy,
    output logic        done,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state, state_next;
    logic [2:0]  op_reg;
    logic [31:0] a_reg, b_reg;
    logic [5:0]  cnt_reg;
    logic [31:0] res_hi_reg, res_lo_reg;

    // Request decode; only meaningful while IDLE
    logic accept, is_mul_op, busy_op;
    assign accept    = start && !flush && (op <= OP_MTLO);
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);

    // 64-bit product: operands extended by one bit so MULT and MULTU share
    // one multiplier; the low 64 bits of the 66-bit product are the result
    logic [32:0] mul_a, mul_b;
    logic [65:0] prod;
    assign mul_a = {(op_reg == OP_MULT) & a_reg[31], a_reg};
    assign mul_b = {(op_reg == OP_MULT) & b_reg[31], b_reg};
    assign prod  = {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};

`ifdef HILO_CTRL_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;

    logic        is_div_op, div_signed;
    logic [31:0] mag_a, mag_b;
    logic [31:0] rem_reg, quo_reg, dvs_reg;
    logic        neg_q_reg, neg_r_reg;
    logic [32:0] shifted, trial;
    logic [31:0] rem_step, quo_step, q_fix, r_fix, div_hi, div_lo;

    assign is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
    assign div_signed = (op == OP_DIV);
    assign mag_a      = (div_signed && operand_a[31]) ? -operand_a : operand_a;
    assign mag_b      = (div_signed && operand_b[31]) ? -operand_b : operand_b;

    // One restoring step: shift the next dividend bit in, keep the
    // difference when the divisor fits
    assign shifted  = {rem_reg, quo_reg[31]};
    assign trial    = shifted - {1'b0, dvs_reg};
    assign rem_step = trial[32] ? shifted[31:0] : trial[31:0];
    assign quo_step = {quo_reg[30:0], ~trial[32]};

    // Sign fix-up applied to the final step; zero divisor overrides it
    assign q_fix  = neg_q_reg ? -quo_step : quo_step;
    assign r_fix  = neg_r_reg ? -rem_step : rem_step;
    assign div_hi = (dvs_reg == 32'd0) ? a_reg : r_fix;
    assign div_lo = (dvs_reg == 32'd0) ? 32'hFFFF_FFFF : q_fix;
    assign busy_op = is_mul_op || is_div_op;

    // Divider working registers: load magnitudes on accept, iterate in DIV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (state == S_IDLE && accept) begin
            rem_reg   <= '0;
            quo_reg   <= mag_a;
            dvs_reg   <= mag_b;
            neg_q_reg <= div_signed && (operand_a[31] ^ operand_b[31]);
            neg_r_reg <= div_signed && operand_a[31];
        end else if (state == S_DIV) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
        end
    end
`else
    assign busy_op = is_mul_op;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op) state_next = S_MUL;
`ifdef HILO_CTRL_DIV_EN
                    else if (is_div_op) state_next = S_DIV;
`endif
                    else state_next = S_WB;
                end
            end
            S_MUL: begin
                if (flush)                    state_next = S_IDLE;
                else if (cnt_reg == MUL_LAST) state_next = S_WB;
            end
            S_DIV: begin
                if (flush)                    state_next = S_IDLE;
                else if (cnt_reg == DIV_LAST) state_next = S_WB;
            end
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, cycle counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_reg     <= op;
                        a_reg      <= operand_a;
                        b_reg      <= operand_b;
                        cnt_reg    <= '0;
                        res_hi_reg <= '0;
                        res_lo_reg <= '0;
                    end
                end
                S_MUL: begin
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == MUL_LAST) begin
                        res_hi_reg <= prod[63:32];
                        res_lo_reg <= prod[31:0];
                    end
                end
                S_DIV: begin
                    cnt_reg <= cnt_reg + 6'd1;
`ifdef HILO_CTRL_DIV_EN
                    if (cnt_reg == DIV_LAST) begin
                        res_hi_reg <= div_hi;
                        res_lo_reg <= div_lo;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs: stall while computing, single-cycle commit in WB
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        hilo_we = 1'b0;
        hi_out  = '0;
        lo_out  = '0;
        case (state)
            S_IDLE:       busy = rst && start && !flush && busy_op;
            S_MUL, S_DIV: busy = 1'b1;
            S_WB: begin
                done    = !flush;
                hilo_we = !flush;
                case (op_reg)
                    OP_MTHI: begin hi_out = a_reg;      lo_out = lo_cur;     end
                    OP_MTLO: begin hi_out = hi_cur;     lo_out = a_reg;      end
                    default: begin hi_out = res_hi_reg; lo_out = res_lo_reg; end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl. Expected HI/LO pairs are queued when a
// request is driven and compared when the DUT raises hilo_we. Works with or
// without HILO_CTRL_DIV_EN defined.
module tb_hilo_ctrl;

    localparam int LAT = 2;
`ifdef HILO_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        flush = 1'b0;
    logic [31:0] hi_cur, lo_cur;
    logic        busy, done, hilo_we;
    logic [31:0] hi_out, lo_out;

    logic [31:0] hi_reg = '0;
    logic [31:0] lo_reg = '0;
    assign hi_cur = hi_reg;
    assign lo_cur = lo_reg;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    hilo_ctrl #(.MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .hi_cur(hi_cur), .lo_cur(lo_cur), .busy(busy), .done(done),
        .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // Bench-side HI/LO register fed by the DUT write port
    always @(posedge clk) begin
        if (hilo_we) begin
            hi_reg <= hi_out;
            lo_reg <= lo_out;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the committed HI/LO pair
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hc,
                                          input logic [31:0] lc);
        longint sa, sb;
        int     ia, ib;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (!DIV_EN) return 64'd0;
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            3'd3: begin
                if (!DIV_EN) return 64'd0;
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, lc};
            3'd5: return {hc, a};
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit stalls(input logic [2:0] o);
        return (o <= 3'd1) || (DIV_EN && (o == 3'd2 || o == 3'd3));
    endfunction

    function automatic int latency(input logic [2:0] o);
        if (o <= 3'd1) return LAT + 1;
        if (DIV_EN && (o == 3'd2 || o == 3'd3)) return 33;
        return 1;
    endfunction

    // Scoreboard consumer: every write must match the oldest expectation
    always @(negedge clk) begin
        if (rst && (hilo_we || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {62'd0, hilo_we, done}, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                $display("txn: hi=%h lo=%h expected hi=%h lo=%h", hi_out, lo_out, e[63:32], e[31:0]);
                check("hilo_data", {hi_out, lo_out}, e);
                check("done_with_we", {63'd0, done}, {63'd0, hilo_we});
            end
        end
    end

    // Issue one request, track busy each cycle and the write-back latency
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int lat;
        int cyc;
        bit busy_ok;
        bit seen;
        lat = latency(o);
        busy_ok = 1'b1;
        seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        exp_q.push_back(model(o, a, b, hi_reg, lo_reg));
        @(negedge clk);
        if (busy !== stalls(o)) busy_ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (busy !== (stalls(o) && cyc < lat)) busy_ok = 1'b0;
            if (hilo_we) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_latency"}, seen ? 64'(cyc) : 64'd999, 64'(lat));
        if (!seen) exp_q.delete();
        check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        @(negedge clk);
        check({tag, "_pulse_end"}, {62'd0, done, hilo_we}, 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] saved_hi;
        int          fl_cyc;
        bit          quiet;

        // Reset: outputs low even with a MULT request presented
        start = 1'b1; op = 3'd0;
        #2;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_outs", {61'd0, done, hilo_we, 1'b0}, 64'd0);
        check("reset_data", {hi_out, lo_out}, 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'd3, 32'd7, 32'd0, "divu_by0");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd2, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
        run_op(3'd4, 32'hAAAA_5555, 32'd0, "mthi");
        run_op(3'd5, 32'h1234_5678, 32'd0, "mtlo");
        check("mtlo_regs", {hi_reg, lo_reg}, {32'hAAAA_5555, 32'h1234_5678});

        // Illegal op is ignored
        @(posedge clk); #1 start = 1'b1; op = 3'd6; operand_a = 32'h5;
        @(negedge clk);
        check("op6_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 start = 1'b0;
        quiet = 1'b1;
        repeat (4) begin @(negedge clk); if (hilo_we || busy) quiet = 1'b0; end
        check("op6_quiet", {63'd0, quiet}, 64'd1);

        // Start together with flush is ignored
        @(posedge clk); #1 start = 1'b1; op = 3'd0; flush = 1'b1;
        @(negedge clk);
        check("startflush_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        quiet = 1'b1;
        repeat (4) begin @(negedge clk); if (hilo_we || busy) quiet = 1'b0; end
        check("startflush_quiet", {63'd0, quiet}, 64'd1);

        // Flush an in-flight long operation
        fl_cyc = DIV_EN ? 10 : 1;
        @(posedge clk); #1 start = 1'b1; op = DIV_EN ? 3'd2 : 3'd0;
        operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (fl_cyc - 1) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        quiet = 1'b1;
        repeat (40) begin @(negedge clk); if (hilo_we || done) quiet = 1'b0; end
        check("flush_no_write", {63'd0, quiet}, 64'd1);
        run_op(3'd1, 32'd5, 32'd6, "multu_after_flush");

        // Flush in the WB cycle suppresses the write
        saved_hi = hi_reg;
        @(posedge clk); #1 start = 1'b1; op = 3'd4; operand_a = 32'hDEAD_BEEF;
        @(posedge clk); #1 start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("wbflush_we_done", {62'd0, hilo_we, done}, 64'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("wbflush_hi_kept", {32'd0, hi_reg}, {32'd0, saved_hi});

        // Asynchronous reset in the middle of an operation
        fl_cyc = DIV_EN ? 15 : 1;
        @(posedge clk); #1 start = 1'b1; op = DIV_EN ? 3'd2 : 3'd0;
        operand_a = 32'd77; operand_b = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (fl_cyc - 1) @(posedge clk);
        #1;
        check("midop_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_outs", {61'd0, busy, done, hilo_we}, 64'd0);
        check("rst_data", {hi_out, lo_out}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_idle", {62'd0, busy, hilo_we}, 64'd0);
        run_op(3'd5, 32'h0BAD_F00D, 32'd0, "mtlo_after_rst");

        // Random mixed traffic
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, DIV_EN ? 3 : 1));
            run_op(ro, $urandom, (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom,
                   "random");
        end
        if (!DIV_EN) run_op(3'd2, 32'd9, 32'd3, "div_disabled");

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
